// File: rtl/branch_predictor.sv
//==============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit counters for fetch prediction,
//               execute-stage branch/jump resolution and perf counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module branch_predictor #(
   parameter int XLEN     = 32,
   parameter int IDX_BITS = 4,
   parameter int TAG_BITS = 8,
   parameter int CNT_W    = 32
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [XLEN-1:0]     i_fetch_pc,
   output logic                o_pred_taken,
   output logic [XLEN-1:0]     o_pred_target,
   input  logic                i_ex_valid,
   input  logic [XLEN-1:0]     i_ex_pc,
   input  logic [2:0]          i_ex_func3,
   input  logic                i_ex_jal,
   input  logic                i_ex_jalr,
   input  logic                i_ex_branch,
   input  logic                i_ex_eq,
   input  logic                i_ex_slt,
   input  logic                i_ex_sltu,
   input  logic [XLEN-1:0]     i_ex_target,
   input  logic                i_ex_pred_taken,
   input  logic [XLEN-1:0]     i_ex_pred_target,
   output logic [1:0]          o_pc_sel,
   output logic                o_mispredict,
   output logic [XLEN-1:0]     o_redirect_pc,
   output logic [CNT_W-1:0]    o_branch_count,
   output logic [CNT_W-1:0]    o_mispredict_count
);

   localparam int DEPTH = 2 ** IDX_BITS;

   logic                valid_q  [DEPTH];
   logic                valid_d  [DEPTH];
   logic [TAG_BITS-1:0] tag_q    [DEPTH];
   logic [TAG_BITS-1:0] tag_d    [DEPTH];
   logic [XLEN-1:0]     target_q [DEPTH];
   logic [XLEN-1:0]     target_d [DEPTH];
   logic [1:0]          ctr_q    [DEPTH];
   logic [1:0]          ctr_d    [DEPTH];

   logic [CNT_W-1:0]    branch_count_q, branch_count_d;
   logic [CNT_W-1:0]    mispredict_count_q, mispredict_count_d;

   logic [IDX_BITS-1:0] f_idx, e_idx;
   logic [TAG_BITS-1:0] f_tag, e_tag;
   logic                f_hit, e_hit;
   logic                cond, taken, is_cf, mispredict;
   logic [XLEN-1:0]     pc_plus4;
   logic                unused_fetch_bits;

   assign f_idx = i_fetch_pc[IDX_BITS+1:2];
   assign f_tag = i_fetch_pc[IDX_BITS+2 +: TAG_BITS];
   assign e_idx = i_ex_pc[IDX_BITS+1:2];
   assign e_tag = i_ex_pc[IDX_BITS+2 +: TAG_BITS];

   // Only index and tag bits of the fetch PC participate in the lookup.
   assign unused_fetch_bits = ^i_fetch_pc;

   assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

   assign o_pred_taken  = f_hit & ctr_q[f_idx][1];
   assign o_pred_target = target_q[f_idx];

   always_comb begin
      cond = 1'b0;
      case (i_ex_func3)
         3'b000:  cond = i_ex_eq;
         3'b001:  cond = ~i_ex_eq;
         3'b100:  cond = i_ex_slt;
         3'b101:  cond = ~i_ex_slt;
         3'b110:  cond = i_ex_sltu;
         3'b111:  cond = ~i_ex_sltu;
         default: cond = 1'b0;
      endcase
   end

   assign is_cf    = i_ex_valid & (i_ex_jal | i_ex_jalr | i_ex_branch);
   assign taken    = i_ex_valid & (i_ex_jal | i_ex_jalr | (i_ex_branch & cond));
   assign pc_plus4 = i_ex_pc + XLEN'(4);

   always_comb begin
      o_pc_sel = 2'b00;
      if (i_ex_valid) begin
         if (i_ex_jal | i_ex_jalr)
            o_pc_sel = 2'b01;
         else if (i_ex_branch & cond)
            o_pc_sel = 2'b11;
      end
   end

   // A non-control instruction that aliased into a taken prediction lands here
   // with taken=0, so it redirects to the fall-through PC.
   assign mispredict    = i_ex_valid &
                          ((taken != i_ex_pred_taken) |
                           (taken & (i_ex_pred_target != i_ex_target)));
   assign o_mispredict  = mispredict;
   assign o_redirect_pc = taken ? i_ex_target : pc_plus4;

   always_comb begin
      valid_d            = valid_q;
      tag_d              = tag_q;
      target_d           = target_q;
      ctr_d              = ctr_q;
      branch_count_d     = branch_count_q + (is_cf ? CNT_W'(1) : CNT_W'(0));
      mispredict_count_d = mispredict_count_q + (mispredict ? CNT_W'(1) : CNT_W'(0));
      if (is_cf) begin
         if (taken) begin
            if (e_hit) begin
               if (ctr_q[e_idx] != 2'b11)
                  ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
               target_d[e_idx] = i_ex_target;
            end else begin
               valid_d[e_idx]  = 1'b1;
               tag_d[e_idx]    = e_tag;
               target_d[e_idx] = i_ex_target;
               ctr_d[e_idx]    = 2'b10;
            end
         end else if (e_hit && (ctr_q[e_idx] != 2'b00)) begin
            ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         valid_q            <= valid_d;
         tag_q              <= tag_d;
         target_q           <= target_d;
         ctr_q              <= ctr_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign o_branch_count     = branch_count_q;
   assign o_mispredict_count = mispredict_count_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
//==============================================================================
// Module      : tb_branch_predictor
// Description : Directed self-checking bench for branch_predictor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_branch_predictor;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [31:0] i_fetch_pc = 32'h100;
   logic        i_ex_valid = 1'b0;
   logic [31:0] i_ex_pc = '0;
   logic [2:0]  i_ex_func3 = '0;
   logic        i_ex_jal = 1'b0, i_ex_jalr = 1'b0, i_ex_branch = 1'b0;
   logic        i_ex_eq = 1'b0, i_ex_slt = 1'b0, i_ex_sltu = 1'b0;
   logic [31:0] i_ex_target = '0;
   logic        i_ex_pred_taken = 1'b0;
   logic [31:0] i_ex_pred_target = '0;

   logic        o_pred_taken, o_mispredict;
   logic [31:0] o_pred_target, o_redirect_pc;
   logic [1:0]  o_pc_sel;
   logic [31:0] o_branch_count, o_mispredict_count;

   logic        w4_pred_taken, w4_mispredict;
   logic [31:0] w4_pred_target, w4_redirect_pc;
   logic [1:0]  w4_pc_sel;
   logic [3:0]  w4_branch_count, w4_mispredict_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 i_clk = ~i_clk;

   branch_predictor dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_fetch_pc(i_fetch_pc),
      .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target),
      .i_ex_valid(i_ex_valid), .i_ex_pc(i_ex_pc), .i_ex_func3(i_ex_func3),
      .i_ex_jal(i_ex_jal), .i_ex_jalr(i_ex_jalr), .i_ex_branch(i_ex_branch),
      .i_ex_eq(i_ex_eq), .i_ex_slt(i_ex_slt), .i_ex_sltu(i_ex_sltu),
      .i_ex_target(i_ex_target), .i_ex_pred_taken(i_ex_pred_taken),
      .i_ex_pred_target(i_ex_pred_target), .o_pc_sel(o_pc_sel),
      .o_mispredict(o_mispredict), .o_redirect_pc(o_redirect_pc),
      .o_branch_count(o_branch_count), .o_mispredict_count(o_mispredict_count)
   );

   branch_predictor #(.CNT_W(4)) dut4 (
      .i_clk(i_clk), .i_rst(i_rst), .i_fetch_pc(i_fetch_pc),
      .o_pred_taken(w4_pred_taken), .o_pred_target(w4_pred_target),
      .i_ex_valid(i_ex_valid), .i_ex_pc(i_ex_pc), .i_ex_func3(i_ex_func3),
      .i_ex_jal(i_ex_jal), .i_ex_jalr(i_ex_jalr), .i_ex_branch(i_ex_branch),
      .i_ex_eq(i_ex_eq), .i_ex_slt(i_ex_slt), .i_ex_sltu(i_ex_sltu),
      .i_ex_target(i_ex_target), .i_ex_pred_taken(i_ex_pred_taken),
      .i_ex_pred_target(i_ex_pred_target), .o_pc_sel(w4_pc_sel),
      .o_mispredict(w4_mispredict), .o_redirect_pc(w4_redirect_pc),
      .o_branch_count(w4_branch_count), .o_mispredict_count(w4_mispredict_count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // kind: 0 none, 1 jal, 2 jalr, 3 branch
   task automatic ex_drive(input logic [31:0] pc, input int kind, input logic [2:0] f3,
                           input logic eq, input logic slt, input logic sltu,
                           input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
      i_ex_valid       = 1'b1;
      i_ex_pc          = pc;
      i_ex_jal         = (kind == 1);
      i_ex_jalr        = (kind == 2);
      i_ex_branch      = (kind == 3);
      i_ex_func3       = f3;
      i_ex_eq          = eq;
      i_ex_slt         = slt;
      i_ex_sltu        = sltu;
      i_ex_target      = tgt;
      i_ex_pred_taken  = pt;
      i_ex_pred_target = ptgt;
      #1;
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
      i_ex_valid = 1'b0;
      #1;
   endtask

   initial begin
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      #1;
      chk("rst_pred_taken", 64'(o_pred_taken), 64'd0);
      chk("rst_pred_target", 64'(o_pred_target), 64'd0);
      chk("rst_bcount", 64'(o_branch_count), 64'd0);
      chk("rst_mcount", 64'(o_mispredict_count), 64'd0);
      chk("rst_pc_sel", 64'(o_pc_sel), 64'd0);
      chk("rst_mispredict", 64'(o_mispredict), 64'd0);

      // beq taken at 0x100, first sighting
      ex_drive(32'h100, 3, 3'b000, 1, 0, 0, 32'h140, 0, 32'h0);
      chk("beq_pc_sel", 64'(o_pc_sel), 64'd3);
      chk("beq_mis", 64'(o_mispredict), 64'd1);
      chk("beq_redir", 64'(o_redirect_pc), 64'h140);
      chk("no_bypass", 64'(o_pred_taken), 64'd0);
      step();
      chk("alloc_pred", 64'(o_pred_taken), 64'd1);
      chk("alloc_target", 64'(o_pred_target), 64'h140);
      chk("bcount1", 64'(o_branch_count), 64'd1);
      chk("mcount1", 64'(o_mispredict_count), 64'd1);

      // not taken: ctr 10 -> 01
      ex_drive(32'h100, 3, 3'b000, 0, 0, 0, 32'h140, 1, 32'h140);
      chk("nt_mis", 64'(o_mispredict), 64'd1);
      chk("nt_redir", 64'(o_redirect_pc), 64'h104);
      chk("nt_pc_sel", 64'(o_pc_sel), 64'd0);
      step();
      chk("ctr01_pred", 64'(o_pred_taken), 64'd0);
      // two more not-taken: 01 -> 00 -> 00
      ex_drive(32'h100, 3, 3'b000, 0, 0, 0, 32'h140, 0, 32'h0);
      chk("nt2_mis", 64'(o_mispredict), 64'd0);
      step();
      ex_drive(32'h100, 3, 3'b000, 0, 0, 0, 32'h140, 0, 32'h0);
      step();
      chk("ctr00_pred", 64'(o_pred_taken), 64'd0);
      // 00 -> 01 still not taken, 01 -> 10 taken
      ex_drive(32'h100, 3, 3'b000, 1, 0, 0, 32'h140, 0, 32'h0);
      step();
      chk("sat_low_pred", 64'(o_pred_taken), 64'd0);
      ex_drive(32'h100, 3, 3'b000, 1, 0, 0, 32'h140, 0, 32'h0);
      step();
      chk("ctr10_pred", 64'(o_pred_taken), 64'd1);
      chk("bcount6", 64'(o_branch_count), 64'd6);
      chk("mcount4", 64'(o_mispredict_count), 64'd4);

      // blt with rs1=-1, rs2=1 at 0x184 (index 1)
      ex_drive(32'h184, 3, 3'b100, 0, 1, 0, 32'h1C0, 0, 32'h0);
      chk("blt_pc_sel", 64'(o_pc_sel), 64'd3);
      chk("blt_redir", 64'(o_redirect_pc), 64'h1C0);
      step();
      i_fetch_pc = 32'h184;
      #1;
      chk("blt_pred", 64'(o_pred_taken), 64'd1);
      chk("blt_target", 64'(o_pred_target), 64'h1C0);

      // bltu same operands at 0x188 (index 2): not taken
      ex_drive(32'h188, 3, 3'b110, 0, 1, 0, 32'h1C0, 0, 32'h0);
      chk("bltu_pc_sel", 64'(o_pc_sel), 64'd0);
      chk("bltu_mis", 64'(o_mispredict), 64'd0);
      chk("bltu_redir", 64'(o_redirect_pc), 64'h18C);
      step();
      i_fetch_pc = 32'h188;
      #1;
      chk("bltu_no_alloc", 64'(o_pred_taken), 64'd0);

      // jalr with wrong predicted target at 0x30C (index 3)
      ex_drive(32'h30C, 2, 3'b000, 0, 0, 0, 32'h204, 1, 32'h200);
      chk("jalr_mis", 64'(o_mispredict), 64'd1);
      chk("jalr_redir", 64'(o_redirect_pc), 64'h204);
      chk("jalr_pc_sel", 64'(o_pc_sel), 64'd1);
      step();
      i_fetch_pc = 32'h30C;
      #1;
      chk("jalr_target", 64'(o_pred_target), 64'h204);

      // invalid execute slot
      ex_drive(32'h310, 1, 3'b000, 0, 0, 0, 32'h600, 1, 32'h0);
      i_ex_valid = 1'b0;
      #1;
      chk("inv_mis", 64'(o_mispredict), 64'd0);
      chk("inv_pc_sel", 64'(o_pc_sel), 64'd0);
      step();
      i_fetch_pc = 32'h310;
      #1;
      chk("inv_no_update", 64'(o_pred_taken), 64'd0);
      chk("bcount9", 64'(o_branch_count), 64'd9);

      // non-control instruction predicted taken
      ex_drive(32'h400, 0, 3'b000, 1, 0, 0, 32'h900, 1, 32'h900);
      chk("alias_mis", 64'(o_mispredict), 64'd1);
      chk("alias_redir", 64'(o_redirect_pc), 64'h404);
      chk("alias_pc_sel", 64'(o_pc_sel), 64'd0);
      step();
      chk("alias_bcount", 64'(o_branch_count), 64'd9);
      chk("alias_mcount", 64'(o_mispredict_count), 64'd7);

      // 0x140 evicts 0x100 at index 0
      ex_drive(32'h140, 1, 3'b000, 0, 0, 0, 32'h500, 0, 32'h0);
      chk("jal_pc_sel", 64'(o_pc_sel), 64'd1);
      step();
      i_fetch_pc = 32'h100;
      #1;
      chk("evict_miss", 64'(o_pred_taken), 64'd0);
      i_fetch_pc = 32'h140;
      #1;
      chk("evict_new_pred", 64'(o_pred_taken), 64'd1);
      chk("evict_new_tgt", 64'(o_pred_target), 64'h500);

      // saturate at 11, then one not-taken keeps predicting taken
      repeat (2) begin
         ex_drive(32'h140, 1, 3'b000, 0, 0, 0, 32'h500, 1, 32'h500);
         step();
      end
      ex_drive(32'h140, 3, 3'b000, 0, 0, 0, 32'h500, 1, 32'h500);
      step();
      chk("sat_high_pred", 64'(o_pred_taken), 64'd1);
      chk("bcount13", 64'(o_branch_count), 64'd13);
      chk("mcount9", 64'(o_mispredict_count), 64'd9);

      // fall-through wraps at top of address space
      ex_drive(32'hFFFF_FFFC, 3, 3'b010, 1, 1, 1, 32'h40, 0, 32'h0);
      chk("wrap_redir", 64'(o_redirect_pc), 64'h0);
      chk("f3_010_pc_sel", 64'(o_pc_sel), 64'd0);
      step();

      // async reset discards the pending update
      ex_drive(32'h314, 1, 3'b000, 0, 0, 0, 32'h700, 0, 32'h0);
      #2 i_rst = 1'b1;
      #1;
      chk("async_rst_bcount", 64'(o_branch_count), 64'd0);
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      i_ex_valid = 1'b0;
      #1;
      i_fetch_pc = 32'h314;
      #1;
      chk("rst_discard", 64'(o_pred_taken), 64'd0);
      i_fetch_pc = 32'h140;
      #1;
      chk("rst_clears_btb", 64'(o_pred_taken), 64'd0);

      // 17 resolved branches: 4-bit counter wraps to 1
      repeat (17) begin
         ex_drive(32'h320, 1, 3'b000, 0, 0, 0, 32'h800, 0, 32'h0);
         step();
      end
      chk("bcount_wrap4", 64'(w4_branch_count), 64'd1);
      chk("mcount_wrap4", 64'(w4_mispredict_count), 64'd1);
      chk("bcount17", 64'(o_branch_count), 64'd17);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
